// File: rtl/tpu_slot_sched.sv
// TPU timing engine: slot prescaler, free-running TIME counter, TX/RX slot FSM
// and the periodic timer interrupt level.
module tpu_slot_sched #(
  parameter int TICK_DIV = 16,
  parameter int SLOT_W   = 8,
  parameter int INT_W    = 16
) (
  input  logic              SYS_CLK,
  input  logic              RST_N,
  input  logic              RSTTPU,
  input  logic              TXSLOT_EN,
  input  logic              RXSLOT_EN,
  input  logic              TIMERINTMSK,
  input  logic [SLOT_W-1:0] TX_SLOT,
  input  logic [SLOT_W-1:0] RX_SLOT,
  input  logic [INT_W-1:0]  TIMER_INT_VALUE,
  input  logic              tx_ack,
  input  logic              int_ack,
  output logic [SLOT_W-1:0] TIME,
  output logic              slot_tick,
  output logic              tx_req,
  output logic              tx_miss,
  output logic              rx_win,
  output logic              rx_conflict,
  output logic              TPUINT_RF
);

  // state   | meaning
  // IDLE    | no slot activity in the current slot
  // TX_REQ  | TX slot open, tx_req held until tx_ack or slot end
  // TX_BUSY | TX accepted, waiting for the next slot boundary
  // RX_WIN  | RX window open for the whole slot
  typedef enum logic [1:0] {IDLE, TX_REQ, TX_BUSY, RX_WIN} state_t;

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_t            r_state;
  logic [PW-1:0]     r_presc;
  logic [SLOT_W-1:0] r_time;
  logic [INT_W-1:0]  r_int_cnt;
  logic              r_slot_tick;
  logic              r_tx_req;
  logic              r_tx_miss;
  logic              r_rx_win;
  logic              r_rx_conflict;
  logic              r_tpuint;

  logic              w_bnd;
  logic [SLOT_W-1:0] w_time_nxt;
  logic              w_tx_hit;
  logic              w_rx_hit;
  logic [INT_W-1:0]  w_int_inc;
  logic              w_period;

  assign w_bnd      = (r_presc == PRESC_MAX);
  assign w_time_nxt = r_time + 1'b1;
  // Slot decisions use the TIME value that becomes visible on this edge
  assign w_tx_hit   = TXSLOT_EN && (TX_SLOT == w_time_nxt);
  assign w_rx_hit   = RXSLOT_EN && (RX_SLOT == w_time_nxt);
  assign w_int_inc  = r_int_cnt + 1'b1;
  assign w_period   = w_bnd && (TIMER_INT_VALUE != '0) && (w_int_inc == TIMER_INT_VALUE);

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= IDLE;
      r_presc       <= '0;
      r_time        <= '0;
      r_int_cnt     <= '0;
      r_slot_tick   <= 1'b0;
      r_tx_req      <= 1'b0;
      r_tx_miss     <= 1'b0;
      r_rx_win      <= 1'b0;
      r_rx_conflict <= 1'b0;
      r_tpuint      <= 1'b0;
    end else if (RSTTPU) begin
      r_state       <= IDLE;
      r_presc       <= '0;
      r_time        <= '0;
      r_int_cnt     <= '0;
      r_slot_tick   <= 1'b0;
      r_tx_req      <= 1'b0;
      r_tx_miss     <= 1'b0;
      r_rx_win      <= 1'b0;
      r_rx_conflict <= 1'b0;
      r_tpuint      <= 1'b0;
    end else begin
      r_slot_tick   <= w_bnd;
      r_tx_miss     <= 1'b0;
      r_rx_conflict <= 1'b0;
      if (w_bnd) begin
        r_presc   <= '0;
        r_time    <= w_time_nxt;
        r_tx_miss <= (r_state == TX_REQ) && !tx_ack;
        if (w_tx_hit) begin
          r_state       <= TX_REQ;
          r_tx_req      <= 1'b1;
          r_rx_win      <= 1'b0;
          r_rx_conflict <= w_rx_hit;
        end else if (w_rx_hit) begin
          r_state  <= RX_WIN;
          r_tx_req <= 1'b0;
          r_rx_win <= 1'b1;
        end else begin
          r_state  <= IDLE;
          r_tx_req <= 1'b0;
          r_rx_win <= 1'b0;
        end
        if (TIMER_INT_VALUE == '0 || w_int_inc == TIMER_INT_VALUE) r_int_cnt <= '0;
        else r_int_cnt <= w_int_inc;
      end else begin
        r_presc <= r_presc + 1'b1;
        if (r_state == TX_REQ && tx_ack) begin
          r_state  <= TX_BUSY;
          r_tx_req <= 1'b0;
        end
      end
      // A period event outranks a coincident acknowledge
      if (w_period && TIMERINTMSK) r_tpuint <= 1'b1;
      else if (int_ack)            r_tpuint <= 1'b0;
    end
  end

  assign TIME        = r_time;
  assign slot_tick   = r_slot_tick;
  assign tx_req      = r_tx_req;
  assign tx_miss     = r_tx_miss;
  assign rx_win      = r_rx_win;
  assign rx_conflict = r_rx_conflict;
  assign TPUINT_RF   = r_tpuint;

endmodule

// File: tb/tb_tpu_slot_sched.sv
// Directed bench for tpu_slot_sched with TICK_DIV=4: table of slot scenarios
// plus hand sequences for interrupt, soft reset and async reset.
module tb_tpu_slot_sched;

  logic       clk = 1'b0;
  logic       RST_N = 1'b0;
  logic       RSTTPU = 1'b0;
  logic       TXSLOT_EN = 1'b0;
  logic       RXSLOT_EN = 1'b0;
  logic       TIMERINTMSK = 1'b0;
  logic [7:0] TX_SLOT = 8'd0;
  logic [7:0] RX_SLOT = 8'd0;
  logic [15:0] TIMER_INT_VALUE = 16'd0;
  logic       tx_ack = 1'b0;
  logic       int_ack = 1'b0;
  logic [7:0] TIME;
  logic       slot_tick, tx_req, tx_miss, rx_win, rx_conflict, TPUINT_RF;

  tpu_slot_sched #(.TICK_DIV(4), .SLOT_W(8), .INT_W(16)) dut (
    .SYS_CLK(clk), .RST_N(RST_N), .RSTTPU(RSTTPU),
    .TXSLOT_EN(TXSLOT_EN), .RXSLOT_EN(RXSLOT_EN), .TIMERINTMSK(TIMERINTMSK),
    .TX_SLOT(TX_SLOT), .RX_SLOT(RX_SLOT), .TIMER_INT_VALUE(TIMER_INT_VALUE),
    .tx_ack(tx_ack), .int_ack(int_ack),
    .TIME(TIME), .slot_tick(slot_tick), .tx_req(tx_req), .tx_miss(tx_miss),
    .rx_win(rx_win), .rx_conflict(rx_conflict), .TPUINT_RF(TPUINT_RF)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit txen;
    bit rxen;
    int txs;
    int rxs;
    int ack_dly;
    int e_req;
    int e_miss;
    int e_rx;
    int e_conf;
    int e_req_t;
    int e_rx_t;
  } vec_t;

  vec_t vecs[6];
  int n_tests = 0;
  int n_fail = 0;
  int kk = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    kk++;
  endtask

  task automatic run_to(input int k);
    while (kk < k) step();
  endtask

  task automatic soft_rst();
    RSTTPU = 1'b1;
    step();
    RSTTPU = 1'b0;
    kk = 0;
  endtask

  function automatic vec_t mk(bit txen, bit rxen, int txs, int rxs, int ack_dly,
                              int e_req, int e_miss, int e_rx, int e_conf,
                              int e_req_t, int e_rx_t);
    vec_t v;
    v.txen = txen; v.rxen = rxen; v.txs = txs; v.rxs = rxs; v.ack_dly = ack_dly;
    v.e_req = e_req; v.e_miss = e_miss; v.e_rx = e_rx; v.e_conf = e_conf;
    v.e_req_t = e_req_t; v.e_rx_t = e_rx_t;
    return v;
  endfunction

  initial begin
    int errs, stray, t1020, t1024, tick1024;
    int req_n, miss_n, rx_n, conf_n, req_t, rx_t, miss_t, tick_ok, acc;

    vecs[0] = mk(1, 0, 5, 7, 2, 2, 0, 0, 0, 5, -1);
    vecs[1] = mk(1, 0, 5, 7, 0, 4, 1, 0, 0, 5, -1);
    vecs[2] = mk(0, 1, 5, 7, 0, 0, 0, 4, 0, -1, 7);
    vecs[3] = mk(1, 1, 7, 7, 1, 1, 0, 0, 1, 7, -1);
    vecs[4] = mk(1, 1, 5, 7, 3, 3, 0, 4, 0, 5, 7);
    vecs[5] = mk(0, 0, 5, 7, 0, 0, 0, 0, 0, -1, -1);

    // Reset state
    step(); step();
    chk("rst_time", TIME, 0);
    chk("rst_outs", {slot_tick, tx_req, tx_miss, rx_win, rx_conflict, TPUINT_RF}, 0);
    RST_N = 1'b1;
    kk = 0;

    // Free-running prescaler and TIME wrap
    errs = 0; stray = 0; t1020 = -1; t1024 = -1; tick1024 = -1;
    for (int k = 1; k <= 1028; k++) begin
      step();
      if (slot_tick != ((k % 4) == 0)) errs++;
      if (TIME != ((k / 4) % 256)) errs++;
      if (tx_req || rx_win || tx_miss || rx_conflict || TPUINT_RF) stray++;
      if (k == 1020) t1020 = TIME;
      if (k == 1024) begin t1024 = TIME; tick1024 = slot_tick; end
    end
    chk("tick_time_seq_errs", errs, 0);
    chk("time_255", t1020, 255);
    chk("time_wrap_0", t1024, 0);
    chk("tick_at_wrap", tick1024, 1);
    chk("idle_no_outputs", stray, 0);

    // Table-driven slot scenarios
    foreach (vecs[i]) begin
      TXSLOT_EN = vecs[i].txen;
      RXSLOT_EN = vecs[i].rxen;
      TX_SLOT = 8'(vecs[i].txs);
      RX_SLOT = 8'(vecs[i].rxs);
      soft_rst();
      req_n = 0; miss_n = 0; rx_n = 0; conf_n = 0;
      req_t = -1; rx_t = -1; miss_t = -1; tick_ok = 1;
      for (int c = 0; c < 40; c++) begin
        step();
        if (tx_req) begin
          if (req_n == 0) begin req_t = TIME; if (!slot_tick) tick_ok = 0; end
          req_n++;
        end
        if (tx_miss) begin miss_n++; miss_t = TIME; end
        if (rx_win) begin
          if (rx_n == 0) begin rx_t = TIME; if (!slot_tick) tick_ok = 0; end
          rx_n++;
        end
        if (rx_conflict) conf_n++;
        tx_ack = (vecs[i].ack_dly != 0) && tx_req && (req_n == vecs[i].ack_dly);
      end
      tx_ack = 1'b0;
      chk($sformatf("v%0d_req_cycles", i), req_n, vecs[i].e_req);
      chk($sformatf("v%0d_miss_pulses", i), miss_n, vecs[i].e_miss);
      chk($sformatf("v%0d_miss_time", i), miss_t,
          (vecs[i].e_miss != 0) ? vecs[i].e_req_t + 1 : -1);
      chk($sformatf("v%0d_rx_cycles", i), rx_n, vecs[i].e_rx);
      chk($sformatf("v%0d_conflicts", i), conf_n, vecs[i].e_conf);
      chk($sformatf("v%0d_req_time", i), req_t, vecs[i].e_req_t);
      chk($sformatf("v%0d_rx_time", i), rx_t, vecs[i].e_rx_t);
      chk($sformatf("v%0d_assert_with_tick", i), tick_ok, 1);
    end

    // Timer interrupt, period 3 slots
    TXSLOT_EN = 1'b0; RXSLOT_EN = 1'b0;
    TIMER_INT_VALUE = 16'd3; TIMERINTMSK = 1'b1;
    soft_rst();
    run_to(11); chk("int_before_3rd", TPUINT_RF, 0);
    run_to(12); chk("int_at_3rd", TPUINT_RF, 1);
    run_to(21); chk("int_hold", TPUINT_RF, 1);
    int_ack = 1'b1; run_to(22); int_ack = 1'b0;
    chk("int_ack_clear", TPUINT_RF, 0);
    run_to(23); chk("int_before_6th", TPUINT_RF, 0);
    run_to(24); chk("int_at_6th", TPUINT_RF, 1);
    run_to(35); int_ack = 1'b1; run_to(36); int_ack = 1'b0;
    chk("int_set_wins_over_ack", TPUINT_RF, 1);

    TIMERINTMSK = 1'b0;
    soft_rst();
    acc = 0;
    for (int c = 0; c < 40; c++) begin step(); if (TPUINT_RF) acc++; end
    chk("int_masked", acc, 0);

    TIMERINTMSK = 1'b1; TIMER_INT_VALUE = 16'd0;
    soft_rst();
    acc = 0;
    for (int c = 0; c < 40; c++) begin step(); if (TPUINT_RF) acc++; end
    chk("int_value0", acc, 0);

    // Soft reset while tx_req is high
    TXSLOT_EN = 1'b1; TX_SLOT = 8'd5; TIMER_INT_VALUE = 16'd3;
    soft_rst();
    run_to(21);
    chk("pre_srst_txreq", tx_req, 1);
    chk("pre_srst_int", TPUINT_RF, 1);
    RSTTPU = 1'b1; step(); RSTTPU = 1'b0;
    chk("srst_time", TIME, 0);
    chk("srst_txreq", tx_req, 0);
    chk("srst_int", TPUINT_RF, 0);
    chk("srst_miss", tx_miss, 0);
    kk = 0; acc = 0;
    for (int c = 0; c < 4; c++) begin step(); if (tx_miss) acc++; end
    chk("srst_no_miss_after", acc, 0);
    chk("srst_first_tick", slot_tick, 1);
    chk("srst_first_time", TIME, 1);

    // Async reset mid-handshake
    run_to(20);
    chk("pre_rstn_txreq", tx_req, 1);
    #3 RST_N = 1'b0;
    #1;
    chk("rstn_time", TIME, 0);
    chk("rstn_outs", {slot_tick, tx_req, tx_miss, rx_win, rx_conflict, TPUINT_RF}, 0);
    step();
    chk("rstn_no_miss", tx_miss, 0);
    RST_N = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
